// File: rtl/vga_ctrl.sv
// 640x480@60 VGA timing generator: free-running pixel/line counters, active-low
// syncs and a bordered eight-bar colour test pattern, all decoded from the counters.
module vga_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_EDGE   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_EDGE   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        active;
    logic        border;
    logic [2:0]  bar;
    logic [11:0] rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Bar index by threshold compare against multiples of the bar width.
    always_comb begin
        bar = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (h_cnt_q >= 10'(k * BAR_W)) bar = 3'(k);
        end
    end

    always_comb begin
        active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        border = (h_cnt_q == '0) || (h_cnt_q == H_EDGE) ||
                 (v_cnt_q == '0) || (v_cnt_q == V_EDGE);
        hsync  = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vsync  = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

        case (bar)
            3'd0:    rgb = 12'hFFF;
            3'd1:    rgb = 12'hFF0;
            3'd2:    rgb = 12'h0FF;
            3'd3:    rgb = 12'h0F0;
            3'd4:    rgb = 12'hF0F;
            3'd5:    rgb = 12'hF00;
            3'd6:    rgb = 12'h00F;
            default: rgb = 12'h000;
        endcase
        if (border) rgb = 12'hFFF;
        if (!active) rgb = '0;

        if (reset) begin
            hsync = 1'b1;
            vsync = 1'b1;
            rgb   = '0;
        end
    end

    assign x     = h_cnt_q;
    assign y     = v_cnt_q;
    assign red   = rgb[11:8];
    assign green = rgb[7:4];
    assign blue  = rgb[3:0];

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl with a shortened vertical frame (12 lines) so that
// a whole frame, its wrap and a mid-frame reset all fit in a short run.
module tb_vga_ctrl;

    localparam int unsigned HT = 800;
    localparam int unsigned VT = 12;   // 6 active + 2 fp + 2 sync + 2 bp

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y;
    logic       hsync, vsync;
    logic [3:0] red, green, blue;

    vga_ctrl #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(6),   .V_FP(2),  .V_SYNC(2),  .V_BP(2)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned n;       // clocks since reset release
        logic [9:0]  ex;
        logic [9:0]  ey;
        logic        ehs;
        logic        evs;
        logic [11:0] ergb;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;
    int unsigned cyc;

    int unsigned hs_low_line0, hs_first_x, vs_low, blank_err, pos_err;

    function automatic vec_t mk(int unsigned n, int unsigned ex, int unsigned ey,
                                logic ehs, logic evs, logic [11:0] ergb);
        vec_t v;
        v.n = n; v.ex = 10'(ex); v.ey = 10'(ey);
        v.ehs = ehs; v.evs = evs; v.ergb = ergb;
        return v;
    endfunction

    task automatic chk(string name, int unsigned act, int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-wide tallies using the bench's own cycle count for position.
    task automatic tally();
        int unsigned hx, vy;
        if (cyc >= HT * VT) return;
        hx = cyc % HT;
        vy = (cyc / HT) % VT;
        if (x != 10'(hx) || y != 10'(vy)) pos_err++;
        if (vy == 0 && !hsync) begin
            if (hs_low_line0 == 0) hs_first_x = hx;
            hs_low_line0++;
        end
        if (!vsync) vs_low++;
        if ((hx >= 640 || vy >= 6) && {red, green, blue} != 12'h000) blank_err++;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        tally();
    endtask

    task automatic chk_all(string tag, logic [9:0] ex, logic [9:0] ey,
                           logic ehs, logic evs, logic [11:0] ergb);
        chk({tag, ".x"},     x, ex);
        chk({tag, ".y"},     y, ey);
        chk({tag, ".hsync"}, hsync, ehs);
        chk({tag, ".vsync"}, vsync, evs);
        chk({tag, ".rgb"},   {red, green, blue}, ergb);
    endtask

    initial begin
        vecs.push_back(mk(0,    0,   0, 1, 1, 12'hFFF));
        vecs.push_back(mk(1,    1,   0, 1, 1, 12'hFFF));
        vecs.push_back(mk(2479, 79,  3, 1, 1, 12'hFFF));
        vecs.push_back(mk(2480, 80,  3, 1, 1, 12'hFF0));
        vecs.push_back(mk(2500, 100, 3, 1, 1, 12'hFF0));
        vecs.push_back(mk(2580, 180, 3, 1, 1, 12'h0FF));
        vecs.push_back(mk(2640, 240, 3, 1, 1, 12'h0F0));
        vecs.push_back(mk(2719, 319, 3, 1, 1, 12'h0F0));
        vecs.push_back(mk(2720, 320, 3, 1, 1, 12'hF0F));
        vecs.push_back(mk(2800, 400, 3, 1, 1, 12'hF00));
        vecs.push_back(mk(2880, 480, 3, 1, 1, 12'h00F));
        vecs.push_back(mk(3000, 600, 3, 1, 1, 12'h000));
        vecs.push_back(mk(3038, 638, 3, 1, 1, 12'h000));
        vecs.push_back(mk(3039, 639, 3, 1, 1, 12'hFFF));
        vecs.push_back(mk(3040, 640, 3, 1, 1, 12'h000));
        vecs.push_back(mk(3055, 655, 3, 1, 1, 12'h000));
        vecs.push_back(mk(3056, 656, 3, 0, 1, 12'h000));
        vecs.push_back(mk(3151, 751, 3, 0, 1, 12'h000));
        vecs.push_back(mk(3152, 752, 3, 1, 1, 12'h000));
        vecs.push_back(mk(3199, 799, 3, 1, 1, 12'h000));
        vecs.push_back(mk(3200, 0,   4, 1, 1, 12'hFFF));
        vecs.push_back(mk(4100, 100, 5, 1, 1, 12'hFFF));
        vecs.push_back(mk(4900, 100, 6, 1, 1, 12'h000));
        vecs.push_back(mk(6399, 799, 7, 1, 1, 12'h000));
        vecs.push_back(mk(6400, 0,   8, 1, 0, 12'h000));
        vecs.push_back(mk(7999, 799, 9, 1, 0, 12'h000));
        vecs.push_back(mk(8000, 0,  10, 1, 1, 12'h000));
        vecs.push_back(mk(9599, 799, 11, 1, 1, 12'h000));
        vecs.push_back(mk(9600, 0,   0, 1, 1, 12'hFFF));

        hs_low_line0 = 0; hs_first_x = 0; vs_low = 0; blank_err = 0; pos_err = 0;
        cyc = 0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset_hold", 10'd0, 10'd0, 1'b1, 1'b1, 12'h000);
        reset = 1'b0;
        #1;
        tally();

        foreach (vecs[i]) begin
            while (cyc < vecs[i].n) step();
            chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
                    vecs[i].ehs, vecs[i].evs, vecs[i].ergb);
        end

        chk("hsync_low_len",  hs_low_line0, 96);
        chk("hsync_first_x",  hs_first_x, 656);
        chk("vsync_low_len",  vs_low, 1600);
        chk("blanking_err",   blank_err, 0);
        chk("position_err",   pos_err, 0);

        // Mid-frame reset at (300,2): outputs must clear without a clock edge.
        while (cyc < 9600 + 2 * HT + 300) step();
        chk_all("pre_reset", 10'd300, 10'd2, 1'b1, 1'b1, 12'h0F0);
        #1;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 10'd0, 10'd0, 1'b1, 1'b1, 12'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("restart0", 10'd0, 10'd0, 1'b1, 1'b1, 12'hFFF);
        @(posedge clk);
        @(negedge clk);
        chk_all("restart1", 10'd1, 10'd0, 1'b1, 1'b1, 12'hFFF);
        repeat (799) @(posedge clk);
        @(negedge clk);
        chk_all("restart_line", 10'd0, 10'd1, 1'b1, 1'b1, 12'hFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
